int_request_ctrl: RTL and testbench



---
 rtl/int_request_ctrl.sv | 172 +++++++++++++++++
 tb/tb_int_request_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_request_ctrl.sv
// Source side of the external-input / doorbell interrupt handshake: synchronised
// irq lines with per-source edge/level pending, a single claim slot, and a doorbell FIFO.
module int_request_ctrl #(
  parameter int NUM_SRC  = 16,
  parameter int DB_DEPTH = 4,
  parameter int DB_WIDTH = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] irq,
  output logic               base_ext_input,
  input  logic               base_ext_input_ack,
  output logic               base_doorbell,
  input  logic               base_doorbell_ack,
  input  logic               reg_we,
  input  logic [2:0]         reg_addr,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata
);

  localparam int AW = $clog2(DB_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [2:0] {
    REG_ENABLE  = 3'd0,
    REG_EDGE    = 3'd1,
    REG_PENDING = 3'd2,
    REG_CLAIM   = 3'd3,
    REG_EOI     = 3'd4,
    REG_DB_POST = 3'd5,
    REG_DB_READ = 3'd6,
    REG_STATUS  = 3'd7
  } reg_sel_e;

  reg_sel_e addr;
  assign addr = reg_sel_e'(reg_addr);

  logic [NUM_SRC-1:0] sync1, s, s_q;
  logic [NUM_SRC-1:0] enable, edge_mode, edge_new, pend_r, pending;
  logic [NUM_SRC-1:0] set_vec, clr_vec, pend_next;
  logic [4:0]         sel, sel_q, claim_id;
  logic               any_sel, req_q, in_service, claim_valid;
  logic               take, eoi;
  logic               wr_enable, wr_edge, wr_pending, wr_eoi, wr_post, wr_dbread;

  logic [DB_WIDTH-1:0] mem [DB_DEPTH];
  logic [PW-1:0]       wptr, rptr, count;
  logic [DB_WIDTH-1:0] db_msg;
  logic                db_ovf, empty, full, pop, push_ok, ovf_set;
  logic [31:0]         count32;

  assign wr_enable  = reg_we && (addr == REG_ENABLE);
  assign wr_edge    = reg_we && (addr == REG_EDGE);
  assign wr_pending = reg_we && (addr == REG_PENDING);
  assign wr_eoi     = reg_we && (addr == REG_EOI);
  assign wr_post    = reg_we && (addr == REG_DB_POST);
  assign wr_dbread  = reg_we && (addr == REG_DB_READ);

  assign edge_new = wr_edge ? reg_wdata[NUM_SRC-1:0] : edge_mode;
  assign pending  = (edge_mode & pend_r) | (~edge_mode & s);
  assign set_vec  = s & ~s_q;

  // Only an ack following a cycle that actually presented a request is a take.
  assign take = base_ext_input_ack && !in_service && req_q;
  assign eoi  = wr_eoi && in_service;

  always_comb begin
    clr_vec = wr_pending ? reg_wdata[NUM_SRC-1:0] : '0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (take && (sel_q == 5'(i))) clr_vec[i] = 1'b1;
  end

  // Pending survives only while the source stays in edge mode; a mode change wipes it.
  assign pend_next = edge_mode & edge_new & (set_vec | (pend_r & ~clr_vec));

  always_comb begin
    sel     = '0;
    any_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (!any_sel && pending[i] && enable[i]) begin
        sel     = 5'(i);
        any_sel = 1'b1;
      end
  end

  assign base_ext_input = any_sel && !in_service;

  assign count   = wptr - rptr;
  assign empty   = (count == '0);
  assign full    = (count == PW'(DB_DEPTH));
  assign pop     = base_doorbell_ack && !empty;
  assign push_ok = wr_post && (!full || pop);
  assign ovf_set = wr_post && full && !pop;
  assign base_doorbell = !empty;
  assign count32 = 32'(count);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1       <= '0;
      s           <= '0;
      s_q         <= '0;
      enable      <= '0;
      edge_mode   <= '0;
      pend_r      <= '0;
      sel_q       <= '0;
      req_q       <= 1'b0;
      in_service  <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= '0;
      wptr        <= '0;
      rptr        <= '0;
      db_msg      <= '0;
      db_ovf      <= 1'b0;
    end else begin
      sync1     <= irq;
      s         <= sync1;
      s_q       <= s;
      sel_q     <= sel;
      req_q     <= base_ext_input;
      pend_r    <= pend_next;
      edge_mode <= edge_new;
      if (wr_enable) enable <= reg_wdata[NUM_SRC-1:0];
      if (take) begin
        claim_id    <= sel_q;
        claim_valid <= 1'b1;
        in_service  <= 1'b1;
      end else if (eoi) begin
        claim_id    <= '0;
        claim_valid <= 1'b0;
        in_service  <= 1'b0;
      end
      if (pop) begin
        db_msg <= mem[rptr[AW-1:0]];
        rptr   <= rptr + PW'(1);
      end
      if (push_ok) wptr <= wptr + PW'(1);
      if (ovf_set) db_ovf <= 1'b1;
      else if (wr_dbread && reg_wdata[31]) db_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= reg_wdata[DB_WIDTH-1:0];
  end

  always_comb begin
    reg_rdata = '0;
    case (addr)
      REG_ENABLE:  reg_rdata[NUM_SRC-1:0] = enable;
      REG_EDGE:    reg_rdata[NUM_SRC-1:0] = edge_mode;
      REG_PENDING: reg_rdata[NUM_SRC-1:0] = pending;
      REG_CLAIM: begin
        reg_rdata[31]  = claim_valid;
        reg_rdata[4:0] = claim_id;
      end
      REG_DB_READ: begin
        reg_rdata[31]           = db_ovf;
        reg_rdata[DB_WIDTH-1:0] = db_msg;
      end
      REG_STATUS: begin
        reg_rdata[15:8] = count32[7:0];
        reg_rdata[1]    = in_service;
        reg_rdata[0]    = base_doorbell;
      end
      default: reg_rdata = '0;
    endcase
  end

  logic unused_ok;
  assign unused_ok = ^{reg_wdata, count32[31:8]};

endmodule

// File: tb/tb_int_request_ctrl.sv
// Randomised bench for int_request_ctrl against a behavioural model, plus directed scenarios.
module tb_int_request_ctrl;
  localparam int N = 16;
  localparam int D = 4;
  localparam int W = 14;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [N-1:0]  irq = '0;
  logic          base_ext_input, base_doorbell;
  logic          ext_ack = 1'b0, db_ack = 1'b0;
  logic          reg_we = 1'b0;
  logic [2:0]    reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [31:0]   reg_rdata;

  int errors = 0;
  int checks = 0;

  int_request_ctrl #(.NUM_SRC(N), .DB_DEPTH(D), .DB_WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .irq(irq),
    .base_ext_input(base_ext_input), .base_ext_input_ack(ext_ack),
    .base_doorbell(base_doorbell), .base_doorbell_ack(db_ack),
    .reg_we(reg_we), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [N-1:0] h1, h2, h3;           // irq as sampled 1, 2, 3 edges ago
  logic [N-1:0] m_en, m_edge, m_pend;
  logic         m_ins, m_cv, m_reqq, m_ovf;
  logic [4:0]   m_cid, m_selq;
  logic [W-1:0] m_msg;
  logic [W-1:0] m_q[$];

  function automatic logic [N-1:0] m_pvec();
    return (m_edge & m_pend) | (~m_edge & h2);
  endfunction

  function automatic int m_sel();
    logic [N-1:0] act;
    act = m_pvec() & m_en;
    for (int i = 0; i < N; i++) if (act[i]) return i;
    return 0;
  endfunction

  function automatic logic m_bei();
    return ((m_pvec() & m_en) != '0) && !m_ins;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] a);
    logic [31:0] r;
    logic [7:0]  cnt;
    r = '0;
    cnt = 8'(m_q.size());
    case (a)
      3'd0: r[N-1:0] = m_en;
      3'd1: r[N-1:0] = m_edge;
      3'd2: r[N-1:0] = m_pvec();
      3'd3: r = {m_cv, 26'd0, m_cid};
      3'd6: r = {m_ovf, 17'd0, m_msg};
      3'd7: r = {16'd0, cnt, 6'd0, m_ins, (m_q.size() != 0)};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [N-1:0] mn_edge;
  int           mn_sel;
  logic         mn_req, mn_take;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h1 = '0; h2 = '0; h3 = '0;
      m_en = '0; m_edge = '0; m_pend = '0;
      m_ins = 0; m_cv = 0; m_reqq = 0; m_ovf = 0;
      m_cid = '0; m_selq = '0; m_msg = '0;
      m_q.delete();
    end else begin
      mn_sel  = m_sel();
      mn_req  = m_bei();
      mn_take = ext_ack && !m_ins && m_reqq;
      mn_edge = (reg_we && reg_addr == 3'd1) ? reg_wdata[N-1:0] : m_edge;
      for (int i = 0; i < N; i++) begin
        logic st, cl;
        st = h2[i] && !h3[i];
        cl = (mn_take && m_selq == 5'(i)) || (reg_we && reg_addr == 3'd2 && reg_wdata[i]);
        m_pend[i] = (m_edge[i] && mn_edge[i]) ? (st || (m_pend[i] && !cl)) : 1'b0;
      end
      m_edge = mn_edge;
      if (reg_we && reg_addr == 3'd0) m_en = reg_wdata[N-1:0];
      if (mn_take) begin
        m_cid = m_selq; m_cv = 1; m_ins = 1;
      end else if (reg_we && reg_addr == 3'd4 && m_ins) begin
        m_cid = '0; m_cv = 0; m_ins = 0;
      end
      m_selq = 5'(mn_sel);
      m_reqq = mn_req;
      if (db_ack && m_q.size() > 0) m_msg = m_q.pop_front();
      if (reg_we && reg_addr == 3'd5) begin
        if (m_q.size() < D) m_q.push_back(reg_wdata[W-1:0]);
        else m_ovf = 1;
      end
      if (reg_we && reg_addr == 3'd6 && reg_wdata[31]) m_ovf = 0;
      h3 = h2; h2 = h1; h1 = irq;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("cmp_ext_input", {31'd0, base_ext_input}, {31'd0, m_bei()});
    chk("cmp_doorbell", {31'd0, base_doorbell}, {31'd0, (m_q.size() != 0)});
    chk("cmp_rdata", reg_rdata, m_rdata(reg_addr));
  end

  task automatic cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    cycle();
    reg_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    reg_addr = a;
    #1;
    chk(nm, reg_rdata, e);
  endtask

  task automatic chkb(input string nm, input logic e);
    chk(nm, {31'd0, base_ext_input}, {31'd0, e});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic       take_next;
  logic [2:0] ra;

  initial begin
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    rd(3'd0, 32'h0, "rst_enable");
    rd(3'd3, 32'h0, "rst_claim");
    rd(3'd7, 32'h0, "rst_status");
    chkb("rst_ext_input", 1'b0);

    // edge source 3: three-edge latency, claim, EOI
    wr(3'd0, 32'h8);
    wr(3'd1, 32'h8);
    irq = 16'h0008; cycle(); irq = '0;
    chkb("t1_edge1", 1'b0);
    cycle(); chkb("t1_edge2", 1'b0);
    cycle(); chkb("t1_edge3", 1'b1);
    cycle();
    ext_ack = 1'b1; cycle(); ext_ack = 1'b0;
    rd(3'd3, 32'h8000_0003, "t1_claim");
    chkb("t1_req_low", 1'b0);
    rd(3'd2, 32'h0, "t1_pending_clr");
    wr(3'd4, 32'h0);
    rd(3'd3, 32'h0, "t1_claim_eoi");

    // level source 5
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h20);
    irq = 16'h0020; cycle(); cycle();
    chkb("t2_level_req", 1'b1);
    wr(3'd2, 32'h20);
    rd(3'd2, 32'h20, "t2_w1c_noeffect");
    ext_ack = 1'b1; cycle(); ext_ack = 1'b0;
    rd(3'd3, 32'h8000_0005, "t2_claim");
    chkb("t2_req_low", 1'b0);
    wr(3'd4, 32'h0);
    chkb("t2_reassert", 1'b1);
    irq = '0; repeat (3) cycle();
    chkb("t2_level_drop", 1'b0);

    // source 7 claimed while source 2 lands during the take cycle
    wr(3'd1, 32'h84);
    wr(3'd0, 32'h84);
    irq = 16'h0080; cycle();
    irq = 16'h0004; cycle();
    irq = '0; cycle();
    chkb("t3_req", 1'b1);
    rd(3'd2, 32'h80, "t3_pend7");
    cycle();
    ext_ack = 1'b1; cycle(); ext_ack = 1'b0;
    rd(3'd3, 32'h8000_0007, "t3_claim7");
    rd(3'd2, 32'h04, "t3_pend2_kept");
    wr(3'd4, 32'h0);
    chkb("t3_reassert2", 1'b1);
    cycle();
    ext_ack = 1'b1; cycle(); ext_ack = 1'b0;
    rd(3'd3, 32'h8000_0002, "t3_claim2");
    wr(3'd4, 32'h0);

    // doorbell overflow and in-order drain
    for (int k = 1; k <= 5; k++) wr(3'd5, 32'(k * 'h11));
    rd(3'd6, 32'h8000_0000, "t4_ovf");
    rd(3'd7, 32'h0000_0401, "t4_status");
    for (int k = 1; k <= 4; k++) begin
      db_ack = 1'b1; cycle(); db_ack = 1'b0;
      rd(3'd6, 32'h8000_0000 | 32'(k * 'h11), "t4_pop");
    end
    chk("t4_db_empty", {31'd0, base_doorbell}, 32'd0);
    wr(3'd6, 32'h8000_0000);
    rd(3'd6, 32'h44, "t4_ovf_clr");

    // push and pop together while full
    for (int k = 1; k <= 4; k++) wr(3'd5, 32'('hA0 + k));
    reg_we = 1'b1; reg_addr = 3'd5; reg_wdata = 32'hA5; db_ack = 1'b1;
    cycle();
    reg_we = 1'b0; db_ack = 1'b0;
    rd(3'd7, 32'h0000_0401, "t5_count");
    rd(3'd6, 32'h0000_00A1, "t5_pop_noovf");
    for (int k = 2; k <= 5; k++) begin
      db_ack = 1'b1; cycle(); db_ack = 1'b0;
      rd(3'd6, 32'('hA0 + k), "t5_drain");
    end

    // reset in mid-handshake, then stray acks
    irq = 16'h0080; cycle(); irq = '0; cycle(); cycle();
    chkb("t6_req", 1'b1);
    wr(3'd5, 32'h3FFF);
    chk("t6_db", {31'd0, base_doorbell}, 32'd1);
    reg_addr = 3'd7;
    #1 reset_n = 1'b0;
    #1;
    chkb("t6_rst_ext", 1'b0);
    chk("t6_rst_db", {31'd0, base_doorbell}, 32'd0);
    chk("t6_rst_status", reg_rdata, 32'd0);
    cycle(); cycle();
    reset_n = 1'b1;
    cycle();
    ext_ack = 1'b1; db_ack = 1'b1; cycle(); ext_ack = 1'b0; db_ack = 1'b0;
    rd(3'd3, 32'h0, "t6_stray_claim");
    rd(3'd7, 32'h0, "t6_stray_status");
    rd(3'd6, 32'h0, "t6_stray_db");

    // randomised traffic against the model
    wr(3'd0, 32'hFFFF);
    wr(3'd1, 32'h00FF);
    take_next = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      ext_ack   = take_next;
      take_next = m_bei() && ($urandom_range(0, 1) == 1);
      db_ack    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) irq = irq ^ N'(1 << $urandom_range(0, N - 1));
      reg_we = ($urandom_range(0, 2) == 0);
      ra = 3'($urandom_range(0, 7));
      if (ra <= 3'd1 && $urandom_range(0, 7) != 0) ra = 3'd2;
      reg_addr  = ra;
      reg_wdata = $urandom();
      cycle();
    end
    ext_ack = 1'b0; db_ack = 1'b0; reg_we = 1'b0;
    cycle(); cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
